lock_reset_seq: RTL

LOCK_RESET_SEQ -- requirements
Module: lock_reset_seq

---
 rtl/lock_reset_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lock_reset_seq.sv
// Power-on/lock-driven reset sequencer: releases sys_reset after a stable PLL lock, then cpu_reset.
// Define LOCK_LOSS_COUNT_EN to build the saturating lock-loss event counter on loss_count.
module lock_reset_seq #(
  parameter int STABLE_CYCLES = 1024,
  parameter int CPU_DELAY     = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clock21,
  input  logic       reset_n,
  input  logic       locked_in,
  output logic       sys_reset,
  output logic       cpu_reset,
  output logic       ready,
  output logic [1:0] state,
  output logic [7:0] loss_count
);

  localparam logic [1:0] IDLE        = 2'b00;
  localparam logic [1:0] WAIT_STABLE = 2'b01;
  localparam logic [1:0] SYS_UP      = 2'b10;
  localparam logic [1:0] RUN         = 2'b11;

  localparam logic [15:0] STABLE_TC = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] CPU_TC    = 16'(CPU_DELAY - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   locked_s;
  logic [1:0]             state_reg;
  logic [1:0]             state_next;
  logic [15:0]            count_reg;
  logic [15:0]            count_next;
  logic                   sys_reset_reg;
  logic                   cpu_reset_reg;
  logic                   ready_reg;

  // Lock synchronizer chain; only the final stage feeds the FSM.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clock21 or negedge reset_n) begin
          if (!reset_n) sync_reg[gi] <= 1'b0;
          else          sync_reg[gi] <= locked_in;
        end
      end else begin : g_next
        always_ff @(posedge clock21 or negedge reset_n) begin
          if (!reset_n) sync_reg[gi] <= 1'b0;
          else          sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  assign locked_s = sync_reg[SYNC_STAGES-1];

  // Lock loss is tested first in every state so it beats a terminal count on the same edge.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        count_next = 16'd0;
        if (locked_s) state_next = WAIT_STABLE;
      end
      WAIT_STABLE: begin
        if (!locked_s) begin
          state_next = IDLE;
          count_next = 16'd0;
        end else if (count_reg == STABLE_TC) begin
          state_next = SYS_UP;
          count_next = 16'd0;
        end else begin
          count_next = count_reg + 16'd1;
        end
      end
      SYS_UP: begin
        if (!locked_s) begin
          state_next = IDLE;
          count_next = 16'd0;
        end else if (count_reg == CPU_TC) begin
          state_next = RUN;
          count_next = 16'd0;
        end else begin
          count_next = count_reg + 16'd1;
        end
      end
      RUN: begin
        if (!locked_s) begin
          state_next = IDLE;
          count_next = 16'd0;
        end
      end
      default: begin
        state_next = IDLE;
        count_next = 16'd0;
      end
    endcase
  end

  // Outputs decode the next state so the resets move on the same edge as the transition.
  always_ff @(posedge clock21 or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      count_reg     <= 16'd0;
      sys_reset_reg <= 1'b1;
      cpu_reset_reg <= 1'b1;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      sys_reset_reg <= (state_next == IDLE) || (state_next == WAIT_STABLE);
      cpu_reset_reg <= (state_next != RUN);
      ready_reg     <= (state_next == RUN);
    end
  end

  assign sys_reset = sys_reset_reg;
  assign cpu_reset = cpu_reset_reg;
  assign ready     = ready_reg;
  assign state     = state_reg;

`ifdef LOCK_LOSS_COUNT_EN
  logic [7:0] loss_reg;

  always_ff @(posedge clock21 or negedge reset_n) begin
    if (!reset_n) begin
      loss_reg <= 8'd0;
    end else if (((state_reg == SYS_UP) || (state_reg == RUN)) && !locked_s
                 && (loss_reg != 8'hFF)) begin
      loss_reg <= loss_reg + 8'd1;
    end
  end

  assign loss_count = loss_reg;
`else
  assign loss_count = 8'd0;
`endif

endmodule
